// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream_if
// Purpose  : FIFO read port plus valid/ready output stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_if #(
    parameter int DWIDTH = 8
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_rden;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;
    logic [1:0]        occupancy;

    // master is the adapter's view; slave is the FIFO + downstream view
    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rden, m_valid, m_data, m_last, occupancy
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rden, m_valid, m_data, m_last, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Drains a show-ahead FIFO read port into a registered, packet-
//            framed valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DWIDTH  = 8,
    parameter int PKT_LEN = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fifo_rd_stream_if.master    bus
);

    localparam int                    c_beat_w    = $clog2(PKT_LEN + 1);
    localparam logic [c_beat_w-1:0]   c_last_beat = c_beat_w'(PKT_LEN - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DWIDTH-1:0]   r_head;
    logic [DWIDTH-1:0]   r_tail;
    logic [1:0]          r_occ;
    logic [c_beat_w-1:0] r_beat;
    logic                w_pop;
    logic                w_drain;
    logic                w_valid;

    assign w_valid = (r_occ != 2'd0);
    assign w_drain = w_valid & bus.m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // INIT masks the FIFO's empty flag for the one edge it reads 0 after reset
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_pop = ~bus.fifo_empty & (r_occ != 2'd2);
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_pop, w_drain})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // New words land in the head slot whenever the head is empty or leaving
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_pop) begin
                if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_drain)) begin
                    r_head <= bus.fifo_dout;
                end else begin
                    r_tail <= bus.fifo_dout;
                end
            end else if (w_drain && (r_occ == 2'd2)) begin
                r_head <= r_tail;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_drain) begin
            if (r_beat == c_last_beat) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + c_beat_w'(1);
            end
        end
    end

    assign bus.fifo_rden = w_pop;
    assign bus.m_valid   = w_valid;
    assign bus.m_data    = r_head;
    assign bus.m_last    = w_valid & (r_beat == c_last_beat);
    assign bus.occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Self-checking bench for fifo_rd_stream with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int c_pkt = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DWIDTH(8)) bus ();

    fifo_rd_stream #(.DWIDTH(8), .PKT_LEN(c_pkt)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Source FIFO contents, pending writes, and stimulus knobs
    logic [7:0] src[$];
    logic [7:0] feed[$];
    int         feed_pct  = 60;
    int         rdy_mode  = 1;
    bit         pop_seen  = 1'b0;

    // Reference model: words held by the adapter, in order, plus drain count
    logic [7:0] exp_q[$];
    int         beat_m = 0;
    bit         run_m  = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    int         drained_total = 0;
    int         sz;
    bit         e_rden;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 32'(bus.m_valid), 0);
            chk("rst_occ",   32'(bus.occupancy), 0);
            chk("rst_last",  32'(bus.m_last), 0);
            chk("rst_data",  32'(bus.m_data), 0);
            chk("rst_rden",  32'(bus.fifo_rden), 0);
            exp_q.delete();
            beat_m     = 0;
            run_m      = 1'b0;
            prev_stall = 1'b0;
            pop_seen   = 1'b0;
        end else begin
            sz     = exp_q.size();
            e_rden = run_m && !bus.fifo_empty && (sz < 2);
            chk("rden",      32'(bus.fifo_rden), 32'(e_rden));
            chk("valid",     32'(bus.m_valid), 32'(sz != 0));
            chk("occupancy", 32'(bus.occupancy), 32'(sz));
            if (sz != 0) begin
                chk("data", 32'(bus.m_data), 32'(exp_q[0]));
                chk("last", 32'(bus.m_last), 32'(beat_m == c_pkt - 1));
            end else begin
                chk("last_idle", 32'(bus.m_last), 0);
            end
            if (prev_stall) begin
                chk("stall_data", 32'(bus.m_data), 32'(prev_data));
                chk("stall_last", 32'(bus.m_last), 32'(prev_last));
            end
            prev_stall = (sz != 0) && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if ((sz != 0) && bus.m_ready) begin
                void'(exp_q.pop_front());
                beat_m = (beat_m + 1) % c_pkt;
                drained_total++;
            end
            if (e_rden) exp_q.push_back(bus.fifo_dout);
            run_m    = 1'b1;
            pop_seen = bus.fifo_rden;
        end
    end

    // All input changes happen 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen && (src.size() > 0)) void'(src.pop_front());
        if ((feed.size() > 0) && ($urandom_range(99) < feed_pct)) src.push_back(feed.pop_front());
        case (rdy_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(1));
        endcase
        bus.fifo_empty = (src.size() == 0);
        bus.fifo_dout  = (src.size() > 0) ? src[0] : 8'hEE;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        src.delete();
        feed.delete();
        bus.fifo_empty = 1'b0;
        bus.fifo_dout  = 8'hEE;
        #1;
        chk("async_rst_valid", 32'(bus.m_valid), 0);
        chk("async_rst_occ",   32'(bus.occupancy), 0);
        chk("async_rst_last",  32'(bus.m_last), 0);
        chk("async_rst_data",  32'(bus.m_data), 0);
        chk("async_rst_rden",  32'(bus.fifo_rden), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] cap_data [0:15];
    logic       cap_last [0:15];

    task automatic collect(input int base, input int n, output int got);
        got = 0;
        for (int c = 0; (c < 200) && (got < n); c++) begin
            tick();
            sample();
            if (bus.m_valid && bus.m_ready) begin
                cap_data[base+got] = bus.m_data;
                cap_last[base+got] = bus.m_last;
                got++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         got;
    int         pops;
    int         d0;
    logic [11:0] frame_mask;
    logic [7:0]  stream_exp [0:4];

    initial begin
        rst            = 1'b1;
        bus.m_ready    = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_dout  = 8'hEE;
        rdy_mode       = 1;
        for (int i = 0; i < 5; i++) src.push_back(8'(i + 1));
        for (int i = 0; i < 5; i++) stream_exp[i] = 8'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset release: INIT blocks the pop for one edge, then 0x01..0x05 stream out
        sample();
        chk("init_rden", 32'(bus.fifo_rden), 0);
        tick();
        sample();
        chk("run_rden", 32'(bus.fifo_rden), 1);
        chk("run_valid_before_pop", 32'(bus.m_valid), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            chk("stream_data",  32'(bus.m_data), 32'(stream_exp[i]));
            chk("stream_valid", 32'(bus.m_valid), 1);
            chk("stream_occ",   32'(bus.occupancy), 1);
        end
        tick();
        sample();
        chk("stream_end_occ",   32'(bus.occupancy), 0);
        chk("stream_end_valid", 32'(bus.m_valid), 0);

        // Backpressure: exactly two pops, head held at 0xA0
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) src.push_back(8'(8'hA0 + i));
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            sample();
            if (bus.fifo_rden) pops++;
        end
        chk("bp_pops", 32'(pops), 2);
        chk("bp_occ",  32'(bus.occupancy), 2);
        chk("bp_data", 32'(bus.m_data), 32'h0A0);
        rdy_mode = 1;
        collect(0, 8, got);
        chk("bp_count", 32'(got), 8);
        for (int i = 0; i < 8; i++) chk("bp_order", 32'(cap_data[i]), 32'(8'hA0 + i));

        // Framing with PKT_LEN=4: last on words 4, 8 and 12
        do_reset();
        for (int i = 0; i < 10; i++) src.push_back(8'(8'h50 + i));
        collect(0, 10, got);
        chk("frame_count10", 32'(got), 10);
        repeat (3) tick();
        src.push_back(8'h5A);
        src.push_back(8'h5B);
        collect(10, 2, got);
        chk("frame_count2", 32'(got), 2);
        frame_mask = 12'b1000_1000_1000;
        for (int i = 0; i < 12; i++) begin
            chk("frame_last", 32'(cap_last[i]), 32'(frame_mask[i]));
            chk("frame_data", 32'(cap_data[i]), 32'(8'h50 + i));
        end

        // Reset at occupancy 2 and beat 2 restarts the packet count
        do_reset();
        for (int i = 0; i < 6; i++) src.push_back(8'(8'h30 + i));
        collect(0, 2, got);
        chk("mid_count", 32'(got), 2);
        rdy_mode = 0;
        repeat (3) tick();
        sample();
        chk("mid_occ", 32'(bus.occupancy), 2);
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) src.push_back(8'(8'h40 + i));
        collect(0, 4, got);
        chk("post_rst_count", 32'(got), 4);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_last", 32'(cap_last[i]), 32'(i == 3));
            chk("post_rst_data", 32'(cap_data[i]), 32'(8'h40 + i));
        end

        // Random ready and FIFO fill over 1000 words
        repeat (4) tick();
        rdy_mode = 2;
        feed_pct = 60;
        d0 = drained_total;
        for (int i = 0; i < 1000; i++) feed.push_back(8'(i * 7 + 3));
        for (int c = 0; (c < 30000) && ((drained_total - d0) < 1000); c++) tick();
        sample();
        chk("rand_drained",   32'(drained_total - d0), 1000);
        chk("rand_src_empty", 32'(src.size() + feed.size()), 0);
        chk("rand_buf_empty", 32'(bus.occupancy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
